// File: rtl/rpe_weight_loader_if.sv
// Weight stream into the loader and the shift-chain bus out to the column.
// Latency: none (wires only).
// Backpressure: w_in is taken only on cycles where w_in_valid and w_in_ready are both high.
interface rpe_weight_loader_if;
    logic [7:0] w_in;
    logic       w_in_valid;
    logic       w_in_ready;
    logic [4:0] Weight_out;
    logic       Weight_out_valid;

    // Producer of raw weights; also observes the column chain.
    modport master (
        output w_in, w_in_valid,
        input  w_in_ready, Weight_out, Weight_out_valid
    );

    // The loader itself.
    modport slave (
        input  w_in, w_in_valid,
        output w_in_ready, Weight_out, Weight_out_valid
    );
endinterface

// File: rtl/rpe_weight_loader.sv
// Encodes SIZE raw 8-bit weights into 5-bit RPE codes and shifts them down one systolic column.
// Latency: Weight_out_valid rises the cycle after the last fill handshake; load_done follows SIZE cycles later.
// Backpressure: w_in_ready is high only while filling; input stalls of any length just hold the fill.
module rpe_weight_loader #(
    parameter int SIZE      = 8,
    parameter int CNT_WIDTH = $clog2(SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rpe_weight_loader_if.slave   bus,
    output logic                 load_done,
    output logic [CNT_WIDTH-1:0] inexact_cnt
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SHIFT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     fill_cnt_q, fill_cnt_d;
    logic [IDX_W-1:0]     shift_cnt_q, shift_cnt_d;
    logic [CNT_WIDTH-1:0] inexact_q, inexact_d;
    logic [4:0]           buf_q [SIZE];
    logic [4:0]           wout_q, wout_d;
    logic                 wvld_q, wvld_d;
    logic                 done_q, done_d;
    logic                 rdy;
    logic                 hs;
    logic                 last_fill;
    logic                 last_shift;
    logic [4:0]           enc_code;
    logic                 enc_inexact;
    logic [4:0]           round_m;

    assign hs         = bus.w_in_valid & rdy;
    assign last_fill  = (fill_cnt_q == IDX_W'(SIZE - 1));
    assign last_shift = (shift_cnt_q == IDX_W'(SIZE - 1));
    // Round-to-nearest multiple of 16; bit 4 set means it overflowed past 15.
    assign round_m    = 5'((9'(bus.w_in) + 9'd8) >> 4);

    // Weight encoder: exact multiples of 16, odd small values, else rounded coarse code.
    always_comb begin
        enc_code    = 5'b1_0000;
        enc_inexact = 1'b0;
        if (bus.w_in == 8'd0) begin
            enc_code = 5'b1_0000;
        end else if (bus.w_in[3:0] == 4'd0) begin
            enc_code = {1'b1, bus.w_in[7:4]};
        end else if (bus.w_in < 8'd32) begin
            enc_code    = {1'b0, bus.w_in[4:1]};
            enc_inexact = ~bus.w_in[0];
        end else begin
            enc_inexact = 1'b1;
            enc_code    = round_m[4] ? 5'b1_1111 : {1'b1, round_m[3:0]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE -> FILL -> SHIFT (SIZE cycles) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FILL;
            S_FILL:  if (hs && last_fill) state_d = S_SHIFT;
            S_SHIFT: if (last_shift) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and counter next values; the last row bypasses the buffer since it lands on the same edge.
    always_comb begin
        rdy         = (state_q == S_FILL);
        wvld_d      = (state_d == S_SHIFT);
        done_d      = (state_d == S_DONE);
        shift_cnt_d = (state_q == S_SHIFT && state_d == S_SHIFT) ? shift_cnt_q + 1'b1 : '0;
        wout_d      = '0;
        if (state_d == S_SHIFT) begin
            wout_d = (state_q == S_FILL) ? enc_code : buf_q[IDX_W'(SIZE - 1) - shift_cnt_d];
        end
        fill_cnt_d = fill_cnt_q;
        if (state_q != S_FILL)  fill_cnt_d = '0;
        else if (hs)            fill_cnt_d = last_fill ? '0 : fill_cnt_q + 1'b1;
        inexact_d = inexact_q;
        if (state_q == S_IDLE)       inexact_d = '0;
        else if (hs && enc_inexact)  inexact_d = inexact_q + 1'b1;
    end

    // Datapath registers: counters, code buffer and the registered chain outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q  <= '0;
            shift_cnt_q <= '0;
            inexact_q   <= '0;
            wout_q      <= '0;
            wvld_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < SIZE; i++) buf_q[i] <= '0;
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            shift_cnt_q <= shift_cnt_d;
            inexact_q   <= inexact_d;
            wout_q      <= wout_d;
            wvld_q      <= wvld_d;
            done_q      <= done_d;
            if (hs) buf_q[fill_cnt_q] <= enc_code;
        end
    end

    assign bus.w_in_ready       = rdy;
    assign bus.Weight_out       = wout_q;
    assign bus.Weight_out_valid = wvld_q;
    assign load_done            = done_q;
    assign inexact_cnt          = inexact_q;
endmodule

// File: tb/tb_rpe_weight_loader.sv
// Randomised bench for rpe_weight_loader with a schedule-based reference model and a PE column model.
// Latency: n/a.
// Backpressure: random w_in_valid stalls and spurious valid during shift.
module tb_rpe_weight_loader;
    localparam int SIZE = 8;
    localparam int CW   = $clog2(SIZE + 1);

    typedef struct packed {
        logic       rdy;
        logic       vld;
        logic [4:0] code;
        logic       done;
    } exp_t;

    localparam exp_t E_IDLE = '{rdy: 1'b0, vld: 1'b0, code: 5'd0, done: 1'b0};
    localparam exp_t E_FILL = '{rdy: 1'b1, vld: 1'b0, code: 5'd0, done: 1'b0};
    localparam exp_t E_DONE = '{rdy: 1'b0, vld: 1'b0, code: 5'd0, done: 1'b1};

    logic clk = 1'b0;
    logic rst_n;
    logic load_done;
    logic [CW-1:0] inexact_cnt;
    always #5 clk = ~clk;

    rpe_weight_loader_if bus();

    rpe_weight_loader #(.SIZE(SIZE), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .load_done   (load_done),
        .inexact_cnt (inexact_cnt)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Column of PEs below the loader: capture on valid, shift down one per cycle.
    logic [4:0] pe [SIZE];
    always @(posedge clk) begin
        if (bus.Weight_out_valid) begin
            pe[0] <= bus.Weight_out;
            for (int k = 1; k < SIZE; k++) pe[k] <= pe[k-1];
        end
    end

    // Reference encoding from the code semantics.
    function automatic logic [4:0] ref_code(input int w);
        int m;
        if (w == 0)       return 5'd16;
        if (w % 16 == 0)  return 5'(16 + w / 16);
        if (w < 32)       return 5'(w / 2);
        m = (w + 8) / 16;
        if (m > 15) m = 15;
        return 5'(16 + m);
    endfunction

    function automatic int code_value(input logic [4:0] c);
        return c[4] ? 16 * int'(c[3:0]) : 2 * int'(c[3:0]) + 1;
    endfunction

    function automatic bit ref_inexact(input int w);
        return code_value(ref_code(w)) != w;
    endfunction

    // Model: empty schedule means "filling"; a completed fill queues the whole shift/done/idle future.
    exp_t sched[$];
    int   m_fill[$];
    int   m_inexact;

    task automatic model_reset();
        sched.delete();
        sched.push_back(E_IDLE);
        m_fill.delete();
        m_inexact = 0;
    endtask

    task automatic model_step();
        exp_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (sched.size() == 0) begin
            if (bus.w_in_valid) begin
                m_fill.push_back(int'(bus.w_in));
                if (ref_inexact(int'(bus.w_in))) m_inexact++;
                if (m_fill.size() == SIZE) begin
                    for (int r = SIZE - 1; r >= 0; r--) begin
                        e.rdy = 1'b0; e.vld = 1'b1; e.code = ref_code(m_fill[r]); e.done = 1'b0;
                        sched.push_back(e);
                    end
                    sched.push_back(E_DONE);
                    sched.push_back(E_IDLE);
                    m_fill.delete();
                end
            end
        end else begin
            void'(sched.pop_front());
            if (sched.size() == 0) m_inexact = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sched.size() != 0) e = sched[0];
        else                   e = E_FILL;
        chk("w_in_ready",       32'(bus.w_in_ready),       32'(e.rdy));
        chk("Weight_out_valid", 32'(bus.Weight_out_valid), 32'(e.vld));
        chk("Weight_out",       32'(bus.Weight_out),       32'(e.code));
        chk("load_done",        32'(load_done),            32'(e.done));
        chk("inexact_cnt",      32'(inexact_cnt),          32'(m_inexact));
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
    endtask

    logic [4:0] cap[$];
    int first_rdy;
    int last_hs;
    int done_cnt = 0;

    task automatic fill_phase(input int w[SIZE], input int stall_pct);
        int  i = 0;
        int  budget = 0;
        bit  v;
        first_rdy = -1;
        while (i < SIZE && budget < 500) begin
            v = ($urandom_range(0, 99) >= stall_pct);
            bus.w_in_valid = v;
            bus.w_in = v ? 8'(w[i]) : 8'($urandom_range(0, 255));
            if (bus.w_in_ready && first_rdy < 0) first_rdy = cyc;
            if (v && bus.w_in_ready) begin
                last_hs = cyc;
                i++;
            end
            tick();
            budget++;
        end
        chk("fill_complete", 32'(i), 32'(SIZE));
    endtask

    task automatic shift_phase(input int w[SIZE], input bit busy);
        int n = 0;
        bit seen = 0;
        cap.delete();
        while (!seen && n < 60) begin
            if (bus.Weight_out_valid) cap.push_back(bus.Weight_out);
            if (load_done) seen = 1;
            else begin
                bus.w_in_valid = busy;
                bus.w_in = 8'($urandom_range(0, 255));
                tick();
                n++;
            end
        end
        bus.w_in_valid = 1'b0;
        chk("load_done_seen", 32'(seen), 32'd1);
        if (seen) done_cnt++;
        chk("valid_cycles", 32'(cap.size()), 32'(SIZE));
        for (int k = 0; k < SIZE; k++) chk("pe_row", 32'(pe[k]), 32'(ref_code(w[k])));
    endtask

    task automatic run_load(input int w[SIZE], input int stall_pct, input bit busy);
        fill_phase(w, stall_pct);
        shift_phase(w, busy);
    endtask

    int w_odd[SIZE]  = '{1, 3, 5, 7, 9, 11, 13, 15};
    int w_cor[SIZE]  = '{0, 16, 240, 31, 2, 40, 255, 200};
    int w_seq[SIZE]  = '{1, 2, 3, 4, 5, 6, 7, 8};
    int w_even[SIZE] = '{2, 4, 6, 8, 10, 12, 14, 18};
    int exp_odd[SIZE] = '{7, 6, 5, 4, 3, 2, 1, 0};
    int exp_cor[SIZE] = '{'h1D, 'h1F, 'h13, 'h01, 'h0F, 'h1F, 'h11, 'h10};
    int exp_pe[SIZE]  = '{0, 1, 1, 2, 2, 3, 3, 4};
    logic [4:0] cap_ref[$];
    int saved_hs;
    int done_base;
    int w_rnd[SIZE];
    int rnd_inexact;

    initial begin
        rst_n = 1'b0;
        bus.w_in = '0;
        bus.w_in_valid = 1'b0;
        repeat (3) tick();
        chk("reset_ready", 32'(bus.w_in_ready), 32'd0);
        chk("reset_valid", 32'(bus.Weight_out_valid), 32'd0);
        chk("reset_wout",  32'(bus.Weight_out), 32'd0);
        chk("reset_done",  32'(load_done), 32'd0);
        chk("reset_inexact", 32'(inexact_cnt), 32'd0);
        rst_n = 1'b1;

        // Odd small weights, no stalls.
        run_load(w_odd, 0, 1'b0);
        for (int k = 0; k < SIZE; k++) chk("odd_code", 32'(cap[k]), 32'(exp_odd[k]));
        chk("odd_inexact", 32'(inexact_cnt), 32'd0);
        saved_hs = last_hs;

        // Encoding corners, back-to-back with the previous load.
        run_load(w_cor, 0, 1'b0);
        chk("gap_hs_to_ready", 32'(first_rdy - saved_hs), 32'(SIZE + 3));
        for (int k = 0; k < SIZE; k++) chk("corner_code", 32'(cap[k]), 32'(exp_cor[k]));
        chk("corner_inexact", 32'(inexact_cnt), 32'd4);
        cap_ref = cap;

        // Same corners with 50% stalls and valid held high during shift.
        run_load(w_cor, 50, 1'b1);
        for (int k = 0; k < SIZE; k++) chk("stall_code", 32'(cap[k]), 32'(cap_ref[k]));
        chk("stall_inexact", 32'(inexact_cnt), 32'd4);

        // Column placement with raw weights 1..8.
        run_load(w_seq, 20, 1'b0);
        for (int k = 0; k < SIZE; k++) chk("pe_literal", 32'(pe[k]), 32'(exp_pe[k]));

        // Reset at shift cycle 3.
        fill_phase(w_cor, 0);
        tick();
        tick();
        model_step();
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_ready",   32'(bus.w_in_ready), 32'd0);
        chk("arst_valid",   32'(bus.Weight_out_valid), 32'd0);
        chk("arst_wout",    32'(bus.Weight_out), 32'd0);
        chk("arst_done",    32'(load_done), 32'd0);
        chk("arst_inexact", 32'(inexact_cnt), 32'd0);
        @(negedge clk);
        compare();
        tick();
        tick();
        rst_n = 1'b1;
        run_load(w_even, 30, 1'b0);
        chk("post_reset_inexact", 32'(inexact_cnt), 32'(SIZE));

        // Two back-to-back loads with independent inexact counts.
        done_base = done_cnt;
        run_load(w_cor, 0, 1'b1);
        saved_hs = last_hs;
        run_load(w_odd, 0, 1'b0);
        chk("b2b_gap", 32'(first_rdy - saved_hs), 32'(SIZE + 3));
        chk("b2b_done_pulses", 32'(done_cnt - done_base), 32'd2);
        chk("b2b_inexact", 32'(inexact_cnt), 32'd0);

        // Random weights, random stall rate, random spurious valid during shift.
        for (int t = 0; t < 6; t++) begin
            rnd_inexact = 0;
            for (int k = 0; k < SIZE; k++) begin
                w_rnd[k] = int'($urandom_range(0, 255));
                if (ref_inexact(w_rnd[k])) rnd_inexact++;
            end
            run_load(w_rnd, int'($urandom_range(0, 70)), 1'($urandom_range(0, 1)));
            chk("rand_inexact", 32'(inexact_cnt), 32'(rnd_inexact));
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
